// File: rtl/mac_seq_pkg.sv
// Shared definitions for the sequenced multiply-accumulate controller:
// FSM state encoding, default operand/result widths and the accumulator
// saturation value used when MAC_SEQ_ACC_EN is defined.
package mac_seq_pkg;

  localparam int DW_DEF = 8;
  localparam int YW_DEF = 18;

  localparam logic [YW_DEF-1:0] ACC_SAT = {YW_DEF{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL_AB = 2'd1,
    MUL_CD = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/mul_u8x8.sv
// Purely combinational unsigned DW x DW multiplier with a full 2*DW-bit
// product. Instantiated once and time-shared by mac_seq_ctrl.
module mul_u8x8
  import mac_seq_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [2*DW-1:0] p
);

  // Operands widened to the product width so no bits are lost.
  assign p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

endmodule

// File: rtl/mac_seq_ctrl.sv
// Computes Y = A*B + C*D with one shared multiplier over two cycles.
// Build option: MAC_SEQ_ACC_EN adds the acc_clr port, accumulates Y across
// transactions and saturates at all-ones.
//
// state  | meaning
// IDLE   | in_ready high, waiting for an operand set
// MUL_AB | multiplier sees A_r*B_r, result loaded into acc
// MUL_CD | multiplier sees C_r*D_r, result added into acc
// DONE   | out_valid high, Y held until out_ready
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int YW = YW_DEF
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic [DW-1:0] C,
  input  logic [DW-1:0] D,
  output logic [YW-1:0] Y,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef MAC_SEQ_ACC_EN
  input  logic          acc_clr,
`endif
  output logic          busy
);

  if (YW < 2*DW+1) begin : g_bad_yw
    $error("mac_seq_ctrl: YW must be at least 2*DW+1");
  end

  state_e          state_q, state_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [YW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   mul_a, mul_b;
  logic [2*DW-1:0] prod;
  logic [YW-1:0]   acc_next;

  mul_u8x8 #(.DW(DW)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  // Multiplier operand select; zero outside the multiply states to keep it quiet.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      MUL_AB: begin
        mul_a = a_q;
        mul_b = b_q;
      end
      MUL_CD: begin
        mul_a = c_q;
        mul_b = d_q;
      end
      default: ;
    endcase
  end

`ifdef MAC_SEQ_ACC_EN
  localparam logic [YW-1:0] SAT_VAL = (YW == YW_DEF) ? YW'(ACC_SAT) : {YW{1'b1}};
  logic [YW:0] sum_ext;

  // One extra carry bit detects overflow; clamp to all-ones once it fires.
  assign sum_ext  = {1'b0, acc_q} + {{(YW+1-2*DW){1'b0}}, prod};
  assign acc_next = sum_ext[YW] ? SAT_VAL : sum_ext[YW-1:0];
`else
  logic [YW-1:0] acc_base;

  // The clear on accept is folded into the MUL_AB load so Y only moves in
  // the two multiply states.
  assign acc_base = (state_q == MUL_AB) ? '0 : acc_q;
  assign acc_next = acc_base + {{(YW-2*DW){1'b0}}, prod};
`endif

  // Next-state, operand capture and accumulator update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
`ifdef MAC_SEQ_ACC_EN
        if (acc_clr) acc_d = '0;
`endif
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          c_d     = C;
          d_d     = D;
          state_d = MUL_AB;
        end
      end
      MUL_AB: begin
        acc_d   = acc_next;
        state_d = MUL_CD;
      end
      MUL_CD: begin
        acc_d   = acc_next;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand and accumulator registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign Y         = acc_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl. Inputs change 1 ns after the rising
// edge and outputs are sampled at that same point.
module tb_mac_seq_ctrl;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  A = '0, B = '0, C = '0, D = '0;
  logic [17:0] Y;
  logic        in_ready, out_valid, busy;
`ifdef MAC_SEQ_ACC_EN
  logic        acc_clr = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  mac_seq_ctrl dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MAC_SEQ_ACC_EN
    .acc_clr   (acc_clr),
`endif
    .busy      (busy)
  );

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  // Present an operand set; in the accumulating build also clear acc so the
  // generic scenarios see a fresh A*B+C*D.
  task automatic drive_ops(input logic [7:0] a, b, c, d);
    A = a; B = b; C = c; D = d;
    in_valid = 1'b1;
`ifdef MAC_SEQ_ACC_EN
    acc_clr = 1'b1;
`endif
  endtask

  task automatic drive_idle;
    in_valid = 1'b0;
`ifdef MAC_SEQ_ACC_EN
    acc_clr = 1'b0;
`endif
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    out_ready = 1'b1;
    drive_idle();
    tick(); tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (Y !== 18'd0) begin bad++; $display("FAIL rst_y: got %0d want 0", Y); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    sys_rst_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic;
    drive_ops(8'd3, 8'd4, 8'd5, 8'd6);
    tick();
    drive_idle();
    A = 8'hAA; B = 8'h55; C = 8'hFF; D = 8'h01;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_t1: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_ov_t1: got %b want 0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_ov_t2: got %b want 0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_ov_t3: got %b want 1", out_valid); end
    total++; if (Y !== 18'd42) begin bad++; $display("FAIL basic_y: got %0d want 42", Y); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_t3: got %b want 0", in_ready); end
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready_t4: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_ov_t4: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_t4: got %b want 0", busy); end
  endtask

  task automatic test_vectors;
    logic [7:0]  va [4] = '{8'd255, 8'd12, 8'd255, 8'd0};
    logic [7:0]  vb [4] = '{8'd255, 8'd34, 8'd1,   8'd200};
    logic [7:0]  vc [4] = '{8'd255, 8'd56, 8'd1,   8'd17};
    logic [7:0]  vd [4] = '{8'd255, 8'd78, 8'd255, 8'd3};
    logic [17:0] vy [4] = '{18'd130050, 18'd4776, 18'd510, 18'd51};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_ops(va[i], vb[i], vc[i], vd[i]);
      tick();
      drive_idle();
      tick(); tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL vec%0d_ov: got %b want 1", i, out_valid); end
      total++; if (Y !== vy[i]) begin bad++; $display("FAIL vec%0d_y: got %0d want %0d", i, Y, vy[i]); end
      total++; if (Y[17] !== 1'b0) begin bad++; $display("FAIL vec%0d_y17: got %b want 0", i, Y[17]); end
      tick();
    end
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    drive_ops(8'd7, 8'd8, 8'd9, 8'd10);
    tick();
    tick(); tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_ov: got %b want 1", out_valid); end
    total++; if (Y !== 18'd146) begin bad++; $display("FAIL stall_y: got %0d want 146", Y); end
    for (int i = 0; i < 5; i++) begin
      A = 8'(20 + i); B = 8'(40 + i); C = 8'(60 + i); D = 8'(80 + i);
      tick();
      total++; if (Y !== 18'd146) begin bad++; $display("FAIL stall_hold%0d_y: got %0d want 146", i, Y); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_hold%0d_in_ready: got %b want 0", i, in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_hold%0d_ov: got %b want 1", i, out_valid); end
    end
    drive_ops(8'd2, 8'd3, 8'd4, 8'd5);
    out_ready = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_release_ov: got %b want 0", out_valid); end
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_reaccept_busy: got %b want 1", busy); end
    drive_idle();
    tick(); tick();
    total++; if (Y !== 18'd26) begin bad++; $display("FAIL stall_next_y: got %0d want 26", Y); end
    tick();
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    drive_ops(8'd1, 8'd2, 8'd3, 8'd4);
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_e0: got %b want 1", busy); end
    tick(); tick();
    total++; if (Y !== 18'd14) begin bad++; $display("FAIL b2b_y0: got %0d want 14", Y); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_ready_done: got %b want 0", in_ready); end
    drive_ops(8'd2, 8'd2, 8'd2, 8'd2);
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready_e3: got %b want 1", in_ready); end
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_e4: got %b want 1", busy); end
    drive_idle();
    tick(); tick();
    total++; if (Y !== 18'd8) begin bad++; $display("FAIL b2b_y1: got %0d want 8", Y); end
    tick();
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    drive_ops(8'd10, 8'd10, 8'd10, 8'd10);
    tick();
    drive_idle();
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy: got %b want 1", busy); end
    sys_rst_n = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_ov: got %b want 0", out_valid); end
    total++; if (Y !== 18'd0) begin bad++; $display("FAIL rmid_y: got %0d want 0", Y); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy_after: got %b want 0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
    sys_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_no_out%0d: got %b want 0", i, out_valid); end
    end
    drive_ops(8'd1, 8'd1, 8'd1, 8'd1);
    tick();
    drive_idle();
    tick(); tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_next_ov: got %b want 1", out_valid); end
    total++; if (Y !== 18'd2) begin bad++; $display("FAIL rmid_next_y: got %0d want 2", Y); end
    tick();
  endtask

`ifdef MAC_SEQ_ACC_EN
  task automatic test_acc_sat;
    logic [17:0] exp_y [3] = '{18'd130050, 18'd260100, 18'd262143};
    out_ready = 1'b1;
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    total++; if (Y !== 18'd0) begin bad++; $display("FAIL acc_clr_idle_y: got %0d want 0", Y); end
    for (int i = 0; i < 3; i++) begin
      A = 8'd255; B = 8'd255; C = 8'd255; D = 8'd255;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      total++; if (Y !== exp_y[i]) begin bad++; $display("FAIL acc_sat%0d_y: got %0d want %0d", i, Y, exp_y[i]); end
      tick();
    end
  endtask

  task automatic test_acc_clr;
    out_ready = 1'b1;
    drive_ops(8'd1, 8'd2, 8'd3, 8'd4);
    tick();
    drive_idle();
    tick(); tick();
    total++; if (Y !== 18'd14) begin bad++; $display("FAIL acc_clr_accept_y: got %0d want 14", Y); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef MAC_SEQ_ACC_EN
    test_acc_sat();
    test_acc_clr();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencing controller that computes Y = A·B + C·D with one shared 8×8 multiplier instead of two parallel multipliers. It sits in front of the training-board arithmetic datapath. Upstream logic hands over the four operands with a valid/ready handshake, and the block returns an 18-bit result with its own valid/ready handshake. It trades throughput (one result per 4 cycles at best) for half the multiplier area.

## Interface
- DW, 8, operand width for A/B/C/D.
- YW, 18, result width; must satisfy YW ≥ 2·DW+1 (elaboration error otherwise).
- sys_clk  in  1  single clock; all state changes on the rising edge.
- sys_rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand set A/B/C/D is valid.
- in_ready  out  1  block accepts an operand set this cycle.
- A, B, C, D  in  DW each  unsigned operands.
- Y  out  YW  unsigned result, zero-extended.
- out_valid  out  1  Y is valid.
- out_ready  in  1  downstream consumes Y.
- busy  out  1  high in every state except IDLE.
- acc_clr  in  1  present only with MAC_SEQ_ACC_EN; see Configuration.

## Operation
- FSM states: IDLE, MUL_AB, MUL_CD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register A/B/C/D into A_r..D_r, clear acc, and go to MUL_AB.
- MUL_AB: multiplier inputs select A_r/B_r; acc <= product; go to MUL_CD.
- MUL_CD: multiplier inputs select C_r/D_r; acc <= acc + product; go to DONE.
- DONE:
  - out_valid=1 and Y=acc.
  - Y and out_valid hold unchanged while out_ready=0.
  - On out_ready=1, go to IDLE.
- Handshakes:
  - in_ready=0 in every state except IDLE.
  - in_valid and operand changes outside IDLE are ignored.
- Arithmetic:
  - Products are 2·DW bits unsigned.
  - The sum is computed at YW bits; max 255·255·2 = 130050, so Y[17] is always 0 without MAC_SEQ_ACC_EN.
- Multiplier input mux defaults to zero in IDLE and DONE, so the multiplier does not toggle there.

## Timing
- Reset values (sys_rst_n=0 at an edge):
  - state=IDLE.
  - in_ready=1 from the first cycle after reset.
  - out_valid=0, Y=0, busy=0.
  - A_r..D_r=0.
- Reset mid-operation aborts the transaction; no out_valid is produced for it.
- Latency: accept edge at cycle t → out_valid=1 at cycle t+3 (states MUL_AB t+1, MUL_CD t+2, DONE t+3).
- Minimum cycle time between accepts is 4 cycles (DONE with out_ready=1 → IDLE → accept).
- Y is a registered output, and is not updated outside MUL_AB/MUL_CD.
- out_valid and in_ready are never high in the same cycle.

## Configuration
- Macro: MAC_SEQ_ACC_EN.
- Defined:
  - acc_clr port exists.
  - acc is not cleared on accept, so Y accumulates across transactions: Y = previous Y + A·B + C·D.
  - Y saturates at 2^YW−1 (262143) and stays there.
  - acc_clr=1 in IDLE clears acc to 0 in that cycle. If an accept happens in the same cycle, the clear applies first.
  - acc_clr is ignored in other states.
- Undefined: no acc_clr port; acc is cleared on every accept; no saturation logic.

## Structure
- Package mac_seq_pkg holds:
  - state encoding (IDLE=2'd0, MUL_AB=2'd1, MUL_CD=2'd2, DONE=2'd3);
  - DW/YW default constants;
  - the saturation constant.
- One sub-module, mul_u8x8: purely combinational unsigned DW×DW multiplier with a 2·DW-bit product, instantiated once.
- FSM, operand registers, mux and accumulator live in mac_seq_ctrl.

## Test plan
- A=3, B=4, C=5, D=6 with in_valid at cycle t and out_ready=1 → out_valid at t+3 with Y=42; in_ready=1 again at t+4.
- A=B=C=D=255 → Y=130050 with Y[17]=0.
- out_ready held low for 5 cycles in DONE, with in_valid=1 and changing operands → Y is stable, in_ready=0, and no new accept occurs; accept happens only after the out_ready pulse.
- sys_rst_n=0 during MUL_CD (operands 10,10,10,10) → next cycle is IDLE with out_valid=0, Y=0, busy=0; the following transaction 1,1,1,1 gives Y=2.
- MAC_SEQ_ACC_EN, operands all 255 for three transactions → Y=130050, then 260100, then 262143 (saturated).
- MAC_SEQ_ACC_EN, acc_clr=1 in the same cycle as the next accept of 1,2,3,4 → Y=14.
